// File: rtl/frame_dump_sched.sv
`timescale 1ns/1ps
// Frame-counting capture-window scheduler: opens dump_en at a programmable frame for a programmable number of frames.
// Optional DUMP_AFTER_DL_EN: hold counting at zero until the ROM download ends, and rearm when a new download starts.
module frame_dump_sched #(
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vs,
   input  logic            downloading,
   input  logic [CNTW-1:0] start_frame,
   input  logic [CNTW-1:0] dump_frames,
   output logic [CNTW-1:0] frame_cnt,
   output logic            dump_en,
   output logic            dump_start,
   output logic            dump_stop,
   output logic            done,
   output logic [1:0]      state_dbg
);

   localparam logic [1:0] ST_COUNT  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;
`ifdef DUMP_AFTER_DL_EN
   localparam logic [1:0] ST_WAIT_DL = 2'd0;
   localparam logic [1:0] ST_INIT    = ST_WAIT_DL;
`else
   localparam logic [1:0] ST_INIT    = ST_COUNT;
`endif

   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            vs_l;
   logic            vs_fall;
   logic [CNTW-1:0] remain;
   logic [CNTW-1:0] remain_nxt;
   logic [CNTW-1:0] cnt_nxt;
   logic [CNTW-1:0] cnt_inc;
   logic            entering_active;
   logic            leaving_active;

`ifdef DUMP_AFTER_DL_EN
   logic dl_l;
   logic dl_rise;
   logic dl_fall;

   assign dl_rise = ~dl_l & downloading;
   assign dl_fall = dl_l & ~downloading;
`else
   logic unused_downloading;

   assign unused_downloading = downloading;
`endif

   assign vs_fall   = vs_l & ~vs;
   assign cnt_inc   = frame_cnt + CNT_ONE;
   assign state_dbg = state;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = frame_cnt;
      remain_nxt = remain;
      case (state)
`ifdef DUMP_AFTER_DL_EN
         ST_WAIT_DL: begin
            cnt_nxt = '0;
            if (dl_fall) state_nxt = ST_COUNT;
         end
`endif
         ST_COUNT: begin
            if (vs_fall) cnt_nxt = cnt_inc;
            // A zero start frame opens the window without waiting for a frame edge.
            if ((start_frame == '0) || (vs_fall && (cnt_inc == start_frame))) begin
               state_nxt  = ST_ACTIVE;
               remain_nxt = dump_frames;
            end
         end
         ST_ACTIVE: begin
            if (vs_fall) begin
               cnt_nxt = cnt_inc;
               // remain==0 means an unlimited window, so it is never decremented.
               if (remain == CNT_ONE) state_nxt = ST_DONE;
               else if (remain != '0) remain_nxt = remain - CNT_ONE;
            end
         end
         ST_DONE: begin
            if (vs_fall) cnt_nxt = cnt_inc;
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
`ifdef DUMP_AFTER_DL_EN
      // A new download aborts whatever is in progress, even a coincident frame edge.
      if (dl_rise) begin
         state_nxt  = ST_WAIT_DL;
         cnt_nxt    = '0;
         remain_nxt = '0;
      end
`endif
   end

   assign entering_active = (state != ST_ACTIVE) && (state_nxt == ST_ACTIVE);
   assign leaving_active  = (state == ST_ACTIVE) && (state_nxt != ST_ACTIVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_INIT;
         frame_cnt  <= '0;
         remain     <= '0;
         vs_l       <= 1'b0;
         dump_en    <= 1'b0;
         dump_start <= 1'b0;
         dump_stop  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_cnt  <= cnt_nxt;
         remain     <= remain_nxt;
         vs_l       <= vs;
         dump_en    <= (state_nxt == ST_ACTIVE);
         dump_start <= entering_active;
         dump_stop  <= leaving_active;
         done       <= (state_nxt == ST_DONE);
      end
   end

`ifdef DUMP_AFTER_DL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dl_l <= 1'b0;
      else     dl_l <= downloading;
   end
`endif

endmodule

// File: tb/tb_frame_dump_sched.sv
`timescale 1ns/1ps
// Randomized bench for frame_dump_sched: a frame-level reference model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_frame_dump_sched;

   localparam int CNTW = 4;
   localparam int W    = CNTW + 4;
   localparam int MODN = 1 << CNTW;
`ifdef DUMP_AFTER_DL_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            vs;
   logic            downloading;
   logic [CNTW-1:0] start_frame;
   logic [CNTW-1:0] dump_frames;
   logic [CNTW-1:0] frame_cnt;
   logic            dump_en;
   logic            dump_start;
   logic            dump_stop;
   logic            done;
   logic [1:0]      state_dbg;

   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];

   // reference model: frame count plus window bookkeeping
   int m_cnt;
   int m_left;
   bit m_wait, m_open, m_fin, m_vs_prev, m_dl_prev;

   frame_dump_sched #(.CNTW(CNTW)) dut (
      .clk         (clk),
      .rst         (rst),
      .vs          (vs),
      .downloading (downloading),
      .start_frame (start_frame),
      .dump_frames (dump_frames),
      .frame_cnt   (frame_cnt),
      .dump_en     (dump_en),
      .dump_start  (dump_start),
      .dump_stop   (dump_stop),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   // Called at each rising edge with the inputs the DUT just sampled.
   task automatic model_step();
      bit fall, dl_rise, dl_fall, was_open, st, sp;
      logic [CNTW-1:0] c;
      st = 1'b0;
      sp = 1'b0;
      if (rst) begin
         m_cnt = 0; m_left = 0; m_wait = FEAT; m_open = 0; m_fin = 0;
         m_vs_prev = 0; m_dl_prev = 0;
      end else begin
         fall     = m_vs_prev && !vs;
         dl_rise  = FEAT && !m_dl_prev && downloading;
         dl_fall  = FEAT && m_dl_prev && !downloading;
         was_open = m_open;
         if (dl_rise) begin
            m_cnt = 0; m_wait = 1; m_open = 0; m_fin = 0; m_left = 0;
         end else if (m_wait) begin
            if (dl_fall) m_wait = 0;
         end else if (!m_open && !m_fin) begin
            if (fall) m_cnt = (m_cnt + 1) % MODN;
            if (start_frame == 0 || (fall && m_cnt == int'(start_frame))) begin
               m_open = 1;
               m_left = int'(dump_frames);
            end
         end else if (m_open) begin
            if (fall) begin
               m_cnt = (m_cnt + 1) % MODN;
               if (m_left == 1) begin
                  m_open = 0;
                  m_fin  = 1;
               end else if (m_left > 1) begin
                  m_left = m_left - 1;
               end
            end
         end else begin
            if (fall) m_cnt = (m_cnt + 1) % MODN;
         end
         st = !was_open && m_open;
         sp = was_open && !m_open;
         m_vs_prev = vs;
         m_dl_prev = downloading;
      end
      c = m_cnt[CNTW-1:0];
      exp_q.push_back({c, m_open, st, sp, m_fin});
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {frame_cnt, dump_en, dump_start, dump_stop, done};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL out_cycle @%0t actual cnt=%0d en=%b start=%b stop=%b done=%b required cnt=%0d en=%b start=%b stop=%b done=%b",
                     $time, a[W-1:4], a[3], a[2], a[1], a[0], e[W-1:4], e[3], e[2], e[1], e[0]);
         end
      end
   end

   task automatic cycle(input logic v, input logic d);
      @(negedge clk);
      vs = v;
      downloading = d;
      @(posedge clk);
      model_step();
   endtask

   // n VS periods with random high/low lengths; downloading may toggle at pct percent per cycle.
   task automatic frames(input int n, input int pct);
      for (int i = 0; i < n; i++) begin
         int h, l;
         h = $urandom_range(1, 3);
         l = $urandom_range(1, 3);
         for (int j = 0; j < h + l; j++) begin
            logic d;
            d = downloading;
            if ($urandom_range(0, 99) < pct) d = ~d;
            cycle(j < h, d);
         end
      end
   endtask

   task automatic dl_pulse(input int n);
      for (int i = 0; i < n; i++) cycle(vs, 1'b1);
      cycle(vs, 1'b0);
   endtask

   // Asserts reset between edges and checks that every output clears at once.
   task automatic do_reset(input int n);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (dump_en !== 1'b0 || dump_start !== 1'b0 || dump_stop !== 1'b0 || done !== 1'b0 || frame_cnt !== '0) begin
         miscompares++;
         $display("FAIL async_reset actual cnt=%0d en=%b start=%b stop=%b done=%b required all zero",
                  frame_cnt, dump_en, dump_start, dump_stop, done);
      end
      @(posedge clk);
      model_step();
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      rst = 1'b0;
      vs = 1'b0;
      downloading = 1'b0;
      @(posedge clk);
      model_step();
   endtask

   task automatic arm();
      if (FEAT) dl_pulse(2);
      else do_reset(2);
   endtask

   initial begin
      rst = 1'b1;
      vs = 1'b0;
      downloading = 1'b0;
      start_frame = 4'd3;
      dump_frames = 4'd2;
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_step();

      // basic window: frames 3-4 open, closes at 5
      arm();
      frames(6, 0);

      // immediate, unlimited window across counter wrap
      start_frame = 4'd0;
      dump_frames = 4'd0;
      arm();
      frames(100, 0);

      // download restart mid-window, then rearm
      start_frame = 4'd2;
      dump_frames = 4'd10;
      arm();
      frames(4, 0);
      dl_pulse(3);
      frames(5, 0);

      // start frame moved behind the counter: matches again after wrap
      start_frame = 4'd9;
      dump_frames = 4'd3;
      arm();
      frames(3, 0);
      start_frame = 4'd2;
      frames(20, 0);

      // downloading noise with a one-frame window
      start_frame = 4'd1;
      dump_frames = 4'd1;
      arm();
      frames(5, FEAT ? 0 : 30);

      // reset in the middle of an open window
      start_frame = 4'd1;
      dump_frames = 4'd0;
      arm();
      frames(3, 0);
      do_reset(2);
      arm();
      frames(3, 0);

      for (int k = 0; k < 10; k++) begin
         start_frame = CNTW'($urandom_range(0, MODN - 1));
         dump_frames = CNTW'($urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) do_reset(1);
         arm();
         frames($urandom_range(0, 12), FEAT ? 2 : 20);
         if ($urandom_range(0, 1) == 1) begin
            start_frame = CNTW'($urandom_range(0, MODN - 1));
            dump_frames = CNTW'($urandom_range(0, 5));
         end
         frames($urandom_range(0, 12), FEAT ? 2 : 20);
      end

      @(negedge clk);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain actual %0d entries left required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
